pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for inter-stage boundaries (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, flush, bubble insertion and an optional 2-entry skid buffer, so upstream stages stall cleanly under back-pressure.
- Control payload is forced to zero whenever the stage holds a bubble, so no spurious reg_write or mem_write can escape.
- Includes a saturating stall counter for performance debug.

Parameters:
- DATA_W, 128: width of the datapath payload (PC, IR, operands, immediate, write address packed by the instantiating stage).
- CTRL_W, 16: width of the control payload (branch, jump, mem_read, mem_write, reg_write, aluop, ...); this field is zeroed on bubbles.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- STALL_W, 16: width of the stall counter.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream holds a valid instruction.
- in_ready, output, 1: stage can accept this cycle.
- in_ctrl, input, CTRL_W: control payload in.
- in_data, input, DATA_W: datapath payload in.
- flush, input, 1: kill all held entries (branch or jump redirect).
- out_valid, output, 1: stage presents a valid instruction.
- out_ready, input, 1: downstream accepts this cycle.
- out_ctrl, output, CTRL_W: control payload out; zero whenever out_valid=0.
- out_data, output, DATA_W: datapath payload out.
- stall_cnt, output, STALL_W: saturating count of stalled cycles.

Behaviour:
- Interface (decided): one clock, clock; reset is synchronous and active-high, named reset.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_valid/in_ctrl/in_data must be held stable while in_valid=1 and in_ready=0.
- Storage: main entry M (drives outputs: M_valid, M_ctrl, M_data) and, when SKID=1, skid entry S (S_valid, S_ctrl, S_data).
- out_valid = M_valid; out_ctrl = M_valid ? M_ctrl : 0; out_data = M_data. out_data is not zeroed on bubbles and holds its last value.
- Reset: all valid bits, M_ctrl, S_ctrl, M_data, S_data and stall_cnt go to 0. After reset: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0. in_ready=1 when SKID=1; when SKID=0, in_ready=1 because M_valid=0.
- SKID=1 state machine (EMPTY / ONE / TWO); in_ready = ~S_valid, driven from a register:
  - EMPTY: in_fire -> M<=in, go to ONE; otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> M<=in, stay ONE (full throughput, 1 instruction/cycle).
  - ONE, out_fire only -> EMPTY.
  - ONE, in_fire only -> S<=in, go to TWO.
  - ONE, neither -> hold.
  - TWO (in_ready=0): out_fire -> M<=S, S_valid<=0, go to ONE; otherwise hold.
- SKID=0: in_ready = ~M_valid | out_ready (combinational). in_fire -> M<=in; out_fire without in_fire -> M_valid<=0.
- Latency: 1 cycle from in_fire to out_valid, with no back-pressure.
- Ordering: strict FIFO; S is never presented before M.
- Flush:
  - Next cycle all valid bits = 0 (state EMPTY), so out_ctrl=0.
  - flush overrides any same-cycle in_fire; that input is discarded and upstream is responsible for killing it.
  - A same-cycle out_fire completes normally downstream.
  - stall_cnt is not cleared by flush.
- Priority: reset > flush > handshake updates.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^STALL_W-1 (no wrap).
  - Cleared only by reset.
- Reset asserted mid-operation (any state): next cycle equals the post-reset values above; held entries are lost.

Test Plan:
- Streaming, SKID=1, out_ready=1: in_valid=1 with in_ctrl=1..5 on consecutive cycles -> out_ctrl=1..5 each one cycle later, in_ready stays 1, stall_cnt=0.
- Back-pressure, SKID=1: deassert out_ready after entry A is held, feed B -> B goes to S, in_ready=0 next cycle, out_ctrl holds A. Re-assert out_ready -> A then B emitted in order, in_ready returns to 1. stall_cnt equals the number of stalled cycles.
- Flush in TWO, with a simultaneous in_valid carrying C -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears at the output.
- Synchronous reset pulsed while in state ONE with out_data=32'hDEADBEEF -> next edge gives out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
- SKID=0: out_ready=0 with M valid -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> pass-through at 1 instruction/cycle.
- STALL_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready handshake, flush, optional skid entry
// and a saturating stall counter; control payload reads as zero on bubbles.
module pipe_stage_reg #(
    parameter int DATA_W  = 128,
    parameter int CTRL_W  = 16,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    logic              w_m_valid;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic [DATA_W-1:0] w_m_data;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [STALL_W-1:0] r_stall_cnt;

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_m_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            logic              r_m_valid;
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_m_ctrl;
            logic [DATA_W-1:0] r_m_data;
            logic [CTRL_W-1:0] r_s_ctrl;
            logic [DATA_W-1:0] r_s_data;

            // in_ready is registered: it drops only once the skid entry is occupied
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_state    <= EMPTY;
                    r_m_valid  <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_m_ctrl   <= '0;
                    r_m_data   <= '0;
                    r_s_ctrl   <= '0;
                    r_s_data   <= '0;
                end else if (flush) begin
                    r_state    <= EMPTY;
                    r_m_valid  <= 1'b0;
                    r_in_ready <= 1'b1;
                end else begin
                    case (r_state)
                        EMPTY: begin
                            if (w_in_fire) begin
                                r_m_ctrl  <= in_ctrl;
                                r_m_data  <= in_data;
                                r_m_valid <= 1'b1;
                                r_state   <= ONE;
                            end
                        end
                        ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                r_m_ctrl <= in_ctrl;
                                r_m_data <= in_data;
                            end else if (w_out_fire) begin
                                r_m_valid <= 1'b0;
                                r_state   <= EMPTY;
                            end else if (w_in_fire) begin
                                r_s_ctrl   <= in_ctrl;
                                r_s_data   <= in_data;
                                r_in_ready <= 1'b0;
                                r_state    <= TWO;
                            end
                        end
                        TWO: begin
                            if (w_out_fire) begin
                                r_m_ctrl   <= r_s_ctrl;
                                r_m_data   <= r_s_data;
                                r_in_ready <= 1'b1;
                                r_state    <= ONE;
                            end
                        end
                        default: begin
                            r_state    <= EMPTY;
                            r_m_valid  <= 1'b0;
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
            end

            assign w_m_valid  = r_m_valid;
            assign w_m_ctrl   = r_m_ctrl;
            assign w_m_data   = r_m_data;
            assign w_in_ready = r_in_ready;
        end else begin : g_single
            logic              r_m_valid;
            logic [CTRL_W-1:0] r_m_ctrl;
            logic [DATA_W-1:0] r_m_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_m_valid <= 1'b0;
                    r_m_ctrl  <= '0;
                    r_m_data  <= '0;
                end else if (flush) begin
                    r_m_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_m_valid <= 1'b1;
                    r_m_ctrl  <= in_ctrl;
                    r_m_data  <= in_data;
                end else if (w_out_fire) begin
                    r_m_valid <= 1'b0;
                end
            end

            assign w_m_valid  = r_m_valid;
            assign w_m_ctrl   = r_m_ctrl;
            assign w_m_data   = r_m_data;
            assign w_in_ready = ~r_m_valid | out_ready;
        end
    endgenerate

    // Counts every cycle a valid entry is refused downstream; sticks at all-ones
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != {STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_m_valid;
    assign out_ctrl  = w_m_valid ? w_m_ctrl : '0;
    assign out_data  = w_m_data;
    assign stall_cnt = r_stall_cnt;

endmodule
